// File: rtl/uga_dyna_txn_ctrl.sv
// Dynamixel protocol-1.0 transaction sequencer.
// Serialises one instruction packet (FF FF ID LEN INSTR P* CHK) into the UART,
// owns the half-duplex bus direction, then parses the servo status packet under
// a per-byte timeout and returns a single response strobe.
module uga_dyna_txn_ctrl #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TURN_CYC    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // Request side (register bank)
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [7:0]  i_req_id,
  input  logic [7:0]  i_req_instr,
  input  logic [2:0]  i_req_nparam,
  input  logic [31:0] i_req_param,
  input  logic        i_req_expect_status,
  // UART TX engine
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic        i_tx_busy,
  // UART RX engine
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  // Bus direction: 0 = we drive, 1 = servo drives
  output logic        o_dyna_bus_oen,
  // Response
  output logic        o_rsp_valid,
  output logic [1:0]  o_rsp_status,
  output logic [7:0]  o_rsp_error,
  output logic [31:0] o_rsp_param,
  output logic [2:0]  o_rsp_nparam,
  output logic        o_busy
);

  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int TURN_W = $clog2(TURN_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_CHKSUM  = 2'b10;
  localparam logic [1:0] ST_FRAME   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_TX_BYTE, S_TX_DRAIN, S_TURN,
    S_RX_HDR1, S_RX_HDR2, S_RX_ID, S_RX_LEN,
    S_RX_ERR, S_RX_PARAM, S_RX_CHK, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  // Registered request
  logic [7:0]  r_id, r_instr;
  logic [2:0]  r_nparam;
  logic [31:0] r_param;
  logic        r_expect;

  // Transmit path
  logic [7:0]        r_tx_data, r_tx_sum;
  logic [3:0]        r_tx_idx;
  logic              r_oen;
  logic [TURN_W-1:0] r_turn_cnt;

  // Receive path
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_rx_sum, r_cap_err;
  logic [2:0]      r_rx_n;
  logic [1:0]      r_rx_idx;
  logic            r_frm;
  logic [31:0]     r_cap_param;

  // Combinational helpers
  logic [3:0] w_tx_idx_next;
  logic [7:0] w_tx_sum_next, w_tx_byte_next;
  logic [1:0] w_param_sel;
  logic       w_accept, w_tx_fire, w_tx_last, w_in_rx, w_len_bad, w_rx_last_param;
  logic [1:0] w_fin_status;
  logic [2:0] w_fin_nparam;

  assign w_accept        = (r_state == S_IDLE) && i_req_valid;
  assign w_tx_fire       = (r_state == S_TX_BYTE) && i_tx_ready;
  assign w_tx_last       = (r_tx_idx == (4'd5 + {1'b0, r_nparam}));
  assign w_in_rx         = (r_state >= S_RX_HDR1) && (r_state <= S_RX_CHK);
  assign w_len_bad       = (i_rx_data < 8'd2) || (i_rx_data > 8'd6);
  assign w_rx_last_param = ({1'b0, r_rx_idx} == (r_rx_n - 3'd1));

  assign o_req_ready    = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_tx_valid     = (r_state == S_TX_BYTE);
  assign o_tx_data      = r_tx_data;
  assign o_dyna_bus_oen = r_oen;
  assign o_rsp_valid    = (r_state == S_DONE);

  // Next outgoing byte and checksum, evaluated for the byte after the current one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_tx_idx_next  = r_tx_idx + 4'd1;
    w_tx_sum_next  = r_tx_sum + ((r_tx_idx >= 4'd2) ? r_tx_data : 8'h00);
    w_param_sel    = w_tx_idx_next[1:0] - 2'd1;  // byte index 5..8 -> P0..P3
    w_tx_byte_next = 8'hFF;
    case (w_tx_idx_next)
      4'd0, 4'd1: w_tx_byte_next = 8'hFF;
      4'd2:       w_tx_byte_next = r_id;
      4'd3:       w_tx_byte_next = {5'b0, r_nparam} + 8'd2;
      4'd4:       w_tx_byte_next = r_instr;
      default: begin
        if (w_tx_idx_next < (4'd5 + {1'b0, r_nparam}))
          w_tx_byte_next = r_param[{w_param_sel, 3'b000} +: 8];
        else
          w_tx_byte_next = ~w_tx_sum_next;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and the status/count to publish on entry to DONE.
  always_comb begin
    w_state_next = r_state;
    w_fin_status = ST_OK;
    w_fin_nparam = 3'd0;
    case (r_state)
      S_IDLE:     if (i_req_valid) w_state_next = S_TX_BYTE;
      S_TX_BYTE:  if (i_tx_ready && w_tx_last) w_state_next = S_TX_DRAIN;
      S_TX_DRAIN: if (!i_tx_busy) w_state_next = S_TURN;
      S_TURN:     if (r_turn_cnt == '0) w_state_next = r_expect ? S_RX_HDR1 : S_DONE;
      S_RX_HDR1:  if (i_rx_valid && i_rx_data == 8'hFF) w_state_next = S_RX_HDR2;
      S_RX_HDR2:  if (i_rx_valid) w_state_next = (i_rx_data == 8'hFF) ? S_RX_ID : S_RX_HDR1;
      S_RX_ID:    if (i_rx_valid && i_rx_data != 8'hFF) w_state_next = S_RX_LEN;
      S_RX_LEN: begin
        if (i_rx_valid) begin
          if (w_len_bad) begin
            w_state_next = S_DONE;
            w_fin_status = ST_FRAME;
          end else begin
            w_state_next = S_RX_ERR;
          end
        end
      end
      S_RX_ERR:   if (i_rx_valid) w_state_next = (r_rx_n == 3'd0) ? S_RX_CHK : S_RX_PARAM;
      S_RX_PARAM: if (i_rx_valid && w_rx_last_param) w_state_next = S_RX_CHK;
      S_RX_CHK: begin
        if (i_rx_valid) begin
          w_state_next = S_DONE;
          w_fin_nparam = r_rx_n;
          if (r_frm)                        w_fin_status = ST_FRAME;
          else if (i_rx_data != ~r_rx_sum)  w_fin_status = ST_CHKSUM;
          else                              w_fin_status = ST_OK;
        end
      end
      S_DONE:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    if (w_in_rx && !i_rx_valid && r_to_cnt == '0) begin
      w_state_next = S_DONE;
      w_fin_status = ST_TIMEOUT;
      w_fin_nparam = 3'd0;
    end
  end

  // Request capture, byte serialisation, drain and bus turnaround.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id       <= '0;
      r_instr    <= '0;
      r_nparam   <= '0;
      r_param    <= '0;
      r_expect   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_sum   <= '0;
      r_tx_idx   <= '0;
      r_oen      <= 1'b1;
      r_turn_cnt <= '0;
    end else if (w_accept) begin
      r_id      <= i_req_id;
      r_instr   <= i_req_instr;
      r_nparam  <= (i_req_nparam > 3'd4) ? 3'd4 : i_req_nparam;
      r_param   <= i_req_param;
      r_expect  <= i_req_expect_status;
      r_tx_data <= 8'hFF;
      r_tx_sum  <= '0;
      r_tx_idx  <= '0;
      r_oen     <= 1'b0;
    end else if (w_tx_fire) begin
      r_tx_sum  <= w_tx_sum_next;
      r_tx_idx  <= w_tx_idx_next;
      r_tx_data <= w_tx_byte_next;
    end else if (r_state == S_TX_DRAIN && !i_tx_busy) begin
      r_turn_cnt <= TURN_LOAD;
    end else if (r_state == S_TURN) begin
      if (r_turn_cnt == '0) r_oen <= 1'b1;
      else                  r_turn_cnt <= r_turn_cnt - 1'b1;
    end
  end

  // Status packet parsing, field capture and the inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt    <= '0;
      r_rx_sum    <= '0;
      r_rx_n      <= '0;
      r_rx_idx    <= '0;
      r_frm       <= 1'b0;
      r_cap_err   <= '0;
      r_cap_param <= '0;
    end else if (w_accept) begin
      r_frm       <= 1'b0;
      r_cap_err   <= '0;
      r_cap_param <= '0;
    end else if (r_state == S_TURN && r_turn_cnt == '0) begin
      r_to_cnt <= TO_LOAD;
      r_frm    <= 1'b0;
    end else if (w_in_rx) begin
      if (i_rx_valid) begin
        r_to_cnt <= TO_LOAD;
        case (r_state)
          S_RX_ID: begin
            if (i_rx_data != 8'hFF) begin
              r_frm    <= (i_rx_data != r_id);
              r_rx_sum <= i_rx_data;
            end
          end
          S_RX_LEN: begin
            if (!w_len_bad) begin
              r_rx_n   <= 3'(i_rx_data - 8'd2);
              r_rx_sum <= r_rx_sum + i_rx_data;
            end
          end
          S_RX_ERR: begin
            r_cap_err <= i_rx_data;
            r_rx_sum  <= r_rx_sum + i_rx_data;
            r_rx_idx  <= '0;
          end
          S_RX_PARAM: begin
            r_cap_param[{r_rx_idx, 3'b000} +: 8] <= i_rx_data;
            r_rx_sum <= r_rx_sum + i_rx_data;
            r_rx_idx <= r_rx_idx + 2'd1;
          end
          default: ;
        endcase
      end else if (r_to_cnt != '0) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end
    end
  end

  // Response fields latch on entry to DONE and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rsp_status <= '0;
      o_rsp_error  <= '0;
      o_rsp_param  <= '0;
      o_rsp_nparam <= '0;
    end else if (w_state_next == S_DONE && r_state != S_DONE) begin
      o_rsp_status <= w_fin_status;
      o_rsp_error  <= r_cap_err;
      o_rsp_param  <= r_cap_param;
      o_rsp_nparam <= w_fin_nparam;
    end
  end

endmodule
